// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Program sequencer that sits directly upstream of the CPU/ALU datapath.
// A small instruction program is written into a local register array and
// then issued to the CPU one instruction at a time. The result of every
// executed ALU operation (an instruction issued with load=0) is captured
// two clock edges after it was issued.
//
// Parameters
//   ADDR_W      program address width, DEPTH = 2**ADDR_W words
//   GAP_CYCLES  idle cycles (cpu_ce low) between issued instructions
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-low reset
//   prog_we       program write strobe (ignored while busy)
//   prog_addr     program write address
//   prog_wdata    instruction: [16]=load [15]=cin [14:8]=opcode [7:0]=data
//   start         single-cycle pulse, begins a run at address 0
//   prog_len      instruction count, sampled on an accepted start
//   hold          stalls issue while high
//   cpu_data_out  CPU result
//   cpu_cout      CPU carry out
//   busy          run in progress
//   done          one-cycle pulse at the end of a run
//   pc            address of the next instruction to issue
//   cpu_data_in   to CPU data_in
//   cpu_opcode    to CPU opcode
//   cpu_cin       to CPU cin
//   cpu_load      to CPU load
//   cpu_ce        to CPU ce
//   last_result   most recently captured cpu_data_out
//   last_cout     most recently captured cpu_cout
// ---------------------------------------------------------------------------
module alu_sequencer #(
   parameter int ADDR_W     = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [16:0]       prog_wdata,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              hold,
   input  logic [7:0]        cpu_data_out,
   input  logic              cpu_cout,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] pc,
   output logic [7:0]        cpu_data_in,
   output logic [6:0]        cpu_opcode,
   output logic              cpu_cin,
   output logic              cpu_load,
   output logic              cpu_ce,
   output logic [7:0]        last_result,
   output logic              last_cout
);

   localparam int DEPTH    = 2 ** ADDR_W;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

   localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_LEN   = 1;
   localparam logic [ADDR_W-1:0] ONE_PC    = 1;
   localparam logic [GAP_W-1:0]  ONE_GAP   = 1;
   localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(GAP_LAST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [16:0]       mem [DEPTH];
   logic [16:0]       cur_word;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   issued;
   logic [ADDR_W:0]   len_clamped;
   logic [GAP_W-1:0]  gap_cnt;
   logic              drain_cnt;
   logic [1:0]        cap_pipe;
   logic              issue_now;
   logic              last_issue;

   // Program memory: plain register array, written only while no run is in
   // progress so a running program can never be modified underneath itself.
   // Contents survive reset on purpose, so a program stays loaded.
   always_ff @(posedge clk) begin
      if (prog_we && !busy) begin
         mem[prog_addr] <= prog_wdata;
      end
   end

   assign cur_word = mem[pc];

   // Decode of the current cycle: run length clamped to the memory depth,
   // whether an instruction leaves this cycle, and whether it is the last one.
   always_comb begin
      len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
      issue_now   = (state == S_ISSUE) && !hold;
      last_issue  = ((issued + ONE_LEN) == len);
   end

   // Next-state logic. The gap phase is skipped entirely for back-to-back
   // issue, and the drain phase always lasts two cycles so the last result
   // has been captured by the time done is raised.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (len_clamped == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!hold) begin
               if (last_issue) begin
                  state_nxt = S_DRAIN;
               end else if (GAP_CYCLES > 0) begin
                  state_nxt = S_GAP;
               end else begin
                  state_nxt = S_ISSUE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_END) begin
               state_nxt = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (drain_cnt) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register plus every registered output. cpu_ce is raised only on
   // the edge that issues an instruction and dropped on every other edge, so
   // it is high for exactly one cycle per instruction (or continuously for
   // back-to-back issue). The capture strobe follows the issue through two
   // stages: stage 0 lines up with cpu_ce, stage 1 with the cycle in which
   // the CPU presents the result, which is then latched on the next edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pc          <= '0;
         len         <= '0;
         issued      <= '0;
         gap_cnt     <= '0;
         drain_cnt   <= 1'b0;
         cap_pipe    <= '0;
         cpu_data_in <= '0;
         cpu_opcode  <= '0;
         cpu_cin     <= 1'b0;
         cpu_load    <= 1'b0;
         cpu_ce      <= 1'b0;
         last_result <= '0;
         last_cout   <= 1'b0;
      end else begin
         state    <= state_nxt;
         done     <= (state_nxt == S_DONE);
         cap_pipe <= {cap_pipe[0], issue_now && !cur_word[16]};

         if (cap_pipe[1]) begin
            last_result <= cpu_data_out;
            last_cout   <= cpu_cout;
         end

         case (state)
            S_IDLE: begin
               cpu_ce   <= 1'b0;
               cpu_load <= 1'b0;
               if (start) begin
                  len    <= len_clamped;
                  pc     <= '0;
                  issued <= '0;
                  busy   <= (len_clamped != '0);
               end
            end
            S_ISSUE: begin
               if (hold) begin
                  cpu_ce   <= 1'b0;
                  cpu_load <= 1'b0;
               end else begin
                  cpu_data_in <= cur_word[7:0];
                  cpu_opcode  <= cur_word[14:8];
                  cpu_cin     <= cur_word[15];
                  cpu_load    <= cur_word[16];
                  cpu_ce      <= 1'b1;
                  pc          <= pc + ONE_PC;
                  issued      <= issued + ONE_LEN;
                  gap_cnt     <= '0;
                  drain_cnt   <= 1'b0;
               end
            end
            S_GAP: begin
               cpu_ce   <= 1'b0;
               cpu_load <= 1'b0;
               gap_cnt  <= gap_cnt + ONE_GAP;
            end
            S_DRAIN: begin
               cpu_ce    <= 1'b0;
               cpu_load  <= 1'b0;
               drain_cnt <= 1'b1;
            end
            default: begin
               cpu_ce   <= 1'b0;
               cpu_load <= 1'b0;
            end
         endcase

         if (state_nxt == S_DONE) begin
            busy <= 1'b0;
         end
      end
   end

endmodule
